// File: rtl/timer_pkg.sv
// timer_pkg: shared digit width, seconds-tens ceiling, digit type and clamp helper
package timer_pkg;
    localparam int W       = 4;
    localparam int MAX_VAL = 5;
    typedef logic [W-1:0] digit_t;
    function automatic digit_t clamp_digit(input digit_t d, input digit_t max);
        return (d > max) ? max : d;
    endfunction
endpackage

// File: rtl/mod6_countdown_digit_next.sv
// digit_next: next-count logic for a BCD down-counter digit (load/clamp, decrement, wrap)
//   cur   : current count
//   data  : preset, clamped to MAX_VAL
//   loadn : active-low load, wins over en
//   en    : decrement enable
//   nxt   : value to register on the next edge
//   MOD6_HOLD_AT_ZERO_EN: when defined, en at 0 holds 0 instead of wrapping
module digit_next #(
    parameter int MAX_VAL = timer_pkg::MAX_VAL,
    parameter int W       = timer_pkg::W
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] data,
    input  logic         loadn,
    input  logic         en,
    output logic [W-1:0] nxt
);
    localparam logic [W-1:0] MAX_W = W'(MAX_VAL);
`ifdef MOD6_HOLD_AT_ZERO_EN
    localparam logic [W-1:0] WRAP = '0;
`else
    localparam logic [W-1:0] WRAP = MAX_W;
`endif
    always_comb begin
        nxt = !loadn ? ((data > MAX_W) ? MAX_W : data) :
              en     ? ((cur != '0) ? cur - W'(1) : WRAP) :
                       cur;
    end
endmodule

// File: rtl/mod6_countdown.sv
// mod6_countdown: mod-6 BCD down-counter digit (tens of seconds) with borrow-out
//   clk   : rising-edge clock
//   clrn  : synchronous active-high clear (highest priority)
//   data  : preset value, loaded when loadn=0 (clamped to MAX_VAL)
//   loadn : synchronous active-low load
//   en    : count enable / borrow-in from the lower digit
//   out   : current count, 0..MAX_VAL
//   tc    : borrow-out, en & (out==0)
//   zero  : out==0
//   MOD6_HOLD_AT_ZERO_EN: when defined, the digit stops at 0 instead of wrapping
module mod6_countdown
    import timer_pkg::*;
#(
    parameter int MAX_VAL = timer_pkg::MAX_VAL,
    parameter int W       = timer_pkg::W
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic [W-1:0] data,
    input  logic         loadn,
    input  logic         en,
    output logic [W-1:0] out,
    output logic         tc,
    output logic         zero
);
    logic [W-1:0] nxt;
    digit_next #(.MAX_VAL(MAX_VAL), .W(W)) u_next (
        .cur  (out),
        .data (data),
        .loadn(loadn),
        .en   (en),
        .nxt  (nxt)
    );
    always_ff @(posedge clk) begin
        if (clrn) out <= '0;
        else      out <= nxt;
    end
    assign zero = (out == '0);
    assign tc   = en & zero;
endmodule

// File: tb/tb_mod6_countdown.sv
// tb_mod6_countdown: directed-vector bench for mod6_countdown
module tb_mod6_countdown;
    logic       clk = 0;
    logic       clrn = 1;
    logic [3:0] data = '0;
    logic       loadn = 1;
    logic       en = 1;
    logic [3:0] out;
    logic       tc, zero;
    int         vectors = 0;
    int         errors = 0;

    mod6_countdown dut (
        .clk  (clk),
        .clrn (clrn),
        .data (data),
        .loadn(loadn),
        .en   (en),
        .out  (out),
        .tc   (tc),
        .zero (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // advance one edge, then check count and the decodes given hand-derived values
    task automatic step(input string tag, input logic [3:0] e_out, input logic e_tc, input logic e_zero);
        tick();
        check({tag, ".out"}, 8'(out), 8'(e_out));
        check({tag, ".tc"}, 8'(tc), 8'(e_tc));
        check({tag, ".zero"}, 8'(zero), 8'(e_zero));
    endtask

    initial begin
        logic [3:0] seq_free [7] = '{5, 4, 3, 2, 1, 0, 5};
        logic [3:0] seq_load [6] = '{3, 2, 1, 0, 5, 4};
        // reset with en=1
        step("reset", 0, 1, 1);
        clrn = 0;
        foreach (seq_free[i]) step($sformatf("free%0d", i), seq_free[i], seq_free[i] == 0, seq_free[i] == 0);
        // load 4 with en=1, then count down through the wrap
        loadn = 0; data = 4;
        tick();
        loadn = 1;
        check("load4.out", 8'(out), 8'd4);
        foreach (seq_load[i]) step($sformatf("load%0d", i), seq_load[i], seq_load[i] == 0, seq_load[i] == 0);
        // clamp
        loadn = 0; data = 9;
        step("clamp9", 5, 0, 0);
        data = 15;
        step("clamp15", 5, 0, 0);
        // hold at 3 with en=0
        data = 3; en = 0;
        step("load3", 3, 0, 0);
        loadn = 1;
        for (int i = 0; i < 10; i++) step($sformatf("hold%0d", i), 3, 0, 0);
        // clear beats load
        clrn = 1; loadn = 0; data = 2; en = 1;
        step("clr_vs_load", 0, 1, 1);
        clrn = 0;
        // load beats enable
        step("load_vs_en", 2, 0, 0);
        // load 0 with en=1: borrow flagged, then wrap (or stop in hold mode)
        data = 0;
        step("load0", 0, 1, 1);
        loadn = 1;
`ifdef MOD6_HOLD_AT_ZERO_EN
        step("load0_next", 0, 1, 1);
        loadn = 0; data = 1;
        step("load1", 1, 0, 0);
        loadn = 1;
        for (int i = 0; i < 3; i++) step($sformatf("stop%0d", i), 0, 1, 1);
`else
        step("load0_wrap", 5, 0, 0);
        loadn = 0; data = 1;
        step("load1", 1, 0, 0);
        loadn = 1;
        step("dec1", 0, 1, 1);
        step("wrap1", 5, 0, 0);
`endif
        // en=0 at zero: no borrow-out
        clrn = 1; en = 0;
        step("zero_noen", 0, 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mod6_countdown.md
# mod6_countdown

Modulo-6 BCD down-counter digit for the microwave timer: holds the tens-of-seconds digit (0–5) of the countdown display. It loads a preset from the keypad path, decrements on each enabled clock, and borrows from the next-higher (minutes) digit via a terminal-count output. It sits between the mod-10 seconds-ones digit, which drives its `en`, and the minutes digit, which its `tc` drives.

## Interface
- `MAX_VAL`, default 5: highest count value; the wrap-around target.
- `W`, default 4: data/count width in bits (BCD nibble).
- `clk` in 1: single clock, rising edge.
- `clrn` in 1: one clock; reset is synchronous and active-high. When sampled 1, the counter clears.
- `data` in W: preset value, loaded when `loadn`=0.
- `loadn` in 1: synchronous active-low load.
- `en` in 1: count enable (borrow-in from the lower digit).
- `out` out W: current count, 0..MAX_VAL.
- `tc` out 1: terminal count (borrow-out) to the next digit.
- `zero` out 1: high when `out`==0.

## Operation
- Priority at each rising `clk` edge: `clrn` > `loadn` > `en` > hold.
- `clrn`=1: `out` <= 0.
- `loadn`=0: `out` <= `data` if `data` <= MAX_VAL, else `out` <= MAX_VAL (clamped). Loading ignores `en`.
- `en`=1: if `out`>0 then `out` <= `out`-1, else `out` <= MAX_VAL (wrap 0→5).
- Otherwise `out` holds.
- `zero` = (`out`==0), combinational from the register.
- `tc` = `en` & (`out`==0), combinational; it flags the cycle in which the digit wraps.
- Arithmetic is unsigned W-bit. `out` never leaves 0..MAX_VAL.

## Timing
- Reset values: `out`=0, `zero`=1, `tc`=`en`. With `en`=1 during reset, `tc`=1.
- Load, decrement and clear each take effect one edge after sampling. Latency is 1 cycle.
- `tc`/`zero` follow `out` with zero latency (no register).
- Load and enable active in the same cycle: load wins, and no decrement occurs that cycle.
- Reset asserted mid-count: `out` is 0 on the next edge regardless of `loadn`/`en`.
- Load of 0 with `en`=1: `tc`=1 on the following cycle, and the next edge wraps to 5.

## Configuration
- `MOD6_HOLD_AT_ZERO_EN`
  - Defined: when `out`==0, `en` does not wrap; `out` stays 0, and `tc` is still asserted as `en` & `zero`. This gives the final digit a stop-at-zero behaviour.
  - Undefined (default): wrap 0→MAX_VAL as in Operation.

## Structure
- Shared package `timer_pkg`: `W`, `MAX_VAL` for the seconds-tens digit (5), `digit_t` (logic [W-1:0]), and a `clamp_digit` constant function.
- One natural sub-module, `digit_next`: combinational next-state logic (load/clamp/decrement/wrap). The top-level wraps it with the state register and the `tc`/`zero` decode.

## Test plan
- Reset: `clrn`=1 for one edge with `en`=1 → `out`=0, `zero`=1, `tc`=1. Release `clrn` → `out` sequence 5,4,3,2,1,0,5 on successive edges.
- Load: `data`=4, `loadn`=0 for one edge, `en`=1 → `out`=4, then 3,2,1,0,5,4. `tc`=1 only while `out`=0.
- Clamp: `data`=9, `loadn`=0 → `out`=5; `data`=15 → `out`=5.
- Hold: `en`=0 after loading 3 → `out` stays 3 for 10 cycles, `tc`=0, `zero`=0.
- Priority: `clrn`=1 and `loadn`=0 (`data`=2) on the same edge → `out`=0. `loadn`=0 (`data`=2) with `en`=1 → `out`=2, not 1.
- With `MOD6_HOLD_AT_ZERO_EN` defined: load 1, `en`=1 → `out` 0, 0, 0…, `tc`=1 from the first 0 onward.
